// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - state encodings, constants and command type shared by mem_arbiter
package mem_arbiter_pkg;

   localparam logic [1:0] ARB_ST_IDLE    = 2'd0;
   localparam logic [1:0] ARB_ST_BUSY_IF = 2'd1;
   localparam logic [1:0] ARB_ST_BUSY_LS = 2'd2;

   localparam logic [3:0] MEM_BE_WORD = 4'hF;

   localparam int ARB_TIMEOUT_DEFAULT = 64;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } mem_cmd_t;

   // Fetches are always full-word reads.
   function automatic mem_cmd_t fetch_cmd(input logic [31:0] addr);
      fetch_cmd = '{we: 1'b0, addr: addr, wdata: 32'h0, be: MEM_BE_WORD};
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, load/store and memory port signals of mem_arbiter
interface mem_arbiter_if;

   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_rvalid_o;

   logic        ls_req_i;
   logic        ls_we_i;
   logic [31:0] ls_addr_i;
   logic [31:0] ls_wdata_i;
   logic [3:0]  ls_be_i;
   logic        ls_rvalid_o;

   logic [31:0] rdata_o;
   logic        err_o;

   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [3:0]  mem_be_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;

   modport slave (
      input  if_req_i, if_addr_i,
      input  ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_be_i,
      input  mem_ack_i, mem_rdata_i,
      output if_rvalid_o, ls_rvalid_o, rdata_o, err_o,
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
   );

   modport master (
      output if_req_i, if_addr_i,
      output ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_be_i,
      output mem_ack_i, mem_rdata_i,
      input  if_rvalid_o, ls_rvalid_o, rdata_o, err_o,
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
   );

endinterface

// File: rtl/arb_timeout_ctr.sv
// rtl/arb_timeout_ctr.sv - busy-cycle counter that flags the last allowed cycle of a memory access
module arb_timeout_ctr
   import mem_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt_q;

   // Fires during the TIMEOUT_CYCLES-th unacknowledged busy cycle so the request drops right after it.
   assign expired_o = en_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fixed-priority fetch/load-store arbiter for one memory port; MEM_ARB_TIMEOUT_EN adds an access timeout
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
   input  logic          clk_i,
   input  logic          rstn_i,
   mem_arbiter_if.slave  bus
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
   end

   logic [1:0]  state_q;
   mem_cmd_t    cmd_q;
   logic [31:0] rdata_q;
   logic        if_rvalid_q;
   logic        ls_rvalid_q;
   logic        err_q;
   logic        busy;
   logic        timeout_hit;

   assign busy = (state_q != ARB_ST_IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
   arb_timeout_ctr #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .clr_i     (!busy),
      .en_i      (busy && !bus.mem_ack_i),
      .expired_o (timeout_hit)
   );
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q     <= ARB_ST_IDLE;
         cmd_q       <= '0;
         rdata_q     <= '0;
         if_rvalid_q <= 1'b0;
         ls_rvalid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         if_rvalid_q <= 1'b0;
         ls_rvalid_q <= 1'b0;
         err_q       <= 1'b0;
         case (state_q)
            // Load/store outranks fetch so the current instruction's data access finishes first.
            ARB_ST_IDLE: begin
               if (bus.ls_req_i) begin
                  cmd_q   <= '{we: bus.ls_we_i, addr: bus.ls_addr_i,
                               wdata: bus.ls_wdata_i, be: bus.ls_be_i};
                  state_q <= ARB_ST_BUSY_LS;
               end else if (bus.if_req_i) begin
                  cmd_q   <= fetch_cmd(bus.if_addr_i);
                  state_q <= ARB_ST_BUSY_IF;
               end
            end
            ARB_ST_BUSY_IF, ARB_ST_BUSY_LS: begin
               // An ack coinciding with the timeout still counts as a normal completion.
               if (bus.mem_ack_i || timeout_hit) begin
                  rdata_q     <= bus.mem_ack_i ? bus.mem_rdata_i : 32'h0;
                  err_q       <= !bus.mem_ack_i;
                  if_rvalid_q <= (state_q == ARB_ST_BUSY_IF);
                  ls_rvalid_q <= (state_q == ARB_ST_BUSY_LS);
                  state_q     <= ARB_ST_IDLE;
               end
            end
            default: state_q <= ARB_ST_IDLE;
         endcase
      end
   end

   assign bus.mem_req_o   = busy;
   assign bus.mem_we_o    = cmd_q.we;
   assign bus.mem_addr_o  = cmd_q.addr;
   assign bus.mem_wdata_o = cmd_q.wdata;
   assign bus.mem_be_o    = cmd_q.be;
   assign bus.rdata_o     = rdata_q;
   assign bus.if_rvalid_o = if_rvalid_q;
   assign bus.ls_rvalid_o = ls_rvalid_q;
   assign bus.err_o       = err_q;

endmodule
